keypad_encoder: RTL and testbench
=================================

# keypad_encoder

- Scans a 4-row × 3-column matrix keypad, synchronises and debounces the column returns, and emits the 4-bit key code consumed by the combination-lock logic.
- Code convention: 0 means no key; a held key shows a nonzero code; the output always returns to 0 between two presses.
- Sits between the keypad pins and the lock input; it is the producing end of that key-code interface.

## Interface
Parameters:
- SCAN_DIV, 16, clock cycles each row is driven (legal ≥4)
- DEBOUNCE, 3, consecutive identical scan frames needed to accept a change (legal 1..15)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- col_i  input  3  column returns, active-high, asynchronous to clk
- row_o  output  4  row drive, one-hot active-high
- key_code  output  4  debounced key code, 0 = none
- key_valid  output  1  one-cycle pulse when key_code goes from 0 to nonzero

## Operation
- Clock and reset: one clock (clk); rst_n asynchronous, active-low.
- Reset values:
  - row_o=4'b0001, key_code=0, key_valid=0.
  - Slot, row and debounce counters = 0.
  - Synchroniser flops and candidate register = 0.
- Synchronisation: col_i passes through a 2-flop synchroniser before use.
- Scanning:
  - row_o drives row r for SCAN_DIV cycles, then advances r→r+1, wrapping 3→0.
  - One frame = 4·SCAN_DIV cycles.
- Sampling:
  - Synchronised columns are sampled on the last cycle of each row slot.
  - A frame accumulates a 12-bit hit vector.
- Key map (row,col → key → code):
  - (0,0..2) → '1','2','3' → 2,3,4
  - (1,·) → '4','5','6' → 5,6,7
  - (2,·) → '7','8','9' → 8,9,10
  - (3,·) → '*','0','#' → 11,1,12
  - Codes 13–15 are never produced.
- Frame candidate: at frame end, candidate = the code of the single hit; 0 if there are no hits or two or more hits (ghost/chord rejection).
- Debounce:
  - If candidate equals the previous frame's candidate, the counter increments, saturating at DEBOUNCE; otherwise the counter is set to 1.
  - When the counter reaches DEBOUNCE, the candidate is "stable".
- Output update, evaluated at each frame end where the stable value S ≠ key_code:
  - key_code=0 and S≠0: key_code←S and key_valid=1 for that cycle.
  - key_code≠0 and S=0: key_code←0.
  - key_code≠0 and S≠0 (direct key change): key_code←0 for at least this frame. S is loaded at the next frame end if still stable. The interface therefore never shows A→B without an intervening 0.
- Reset mid-frame: immediate return to reset values. Scanning restarts at row 0 on the first clock after deassertion.

## Timing
- key_code and key_valid are registered and change only on the cycle after a frame's final sample.
- Press latency, for a clean press held continuously:
  - At least DEBOUNCE·4·SCAN_DIV cycles.
  - At most (DEBOUNCE+1)·4·SCAN_DIV+3 cycles, including the 2-cycle synchroniser and the registered output.
- Release latency: same bounds as press latency.
- key_valid is exactly one cycle wide and never asserts on a release or on the 0 gap of a direct change.
- Bounce shorter than one frame resets the debounce counter; a change shorter than DEBOUNCE frames never reaches key_code.
- Counter widths: slot counter is $clog2(SCAN_DIV) bits; debounce counter is 4 bits.

## Structure
- Shared package keypad_pkg holds:
  - Code constants KEY_NONE=0, KEY_0=1, KEY_1..KEY_9=2..10, KEY_STAR=11, KEY_HASH=12.
  - The row/column→code mapping function.
  - NUM_ROWS=4 and NUM_COLS=3.
- One sub-module, keypad_debounce:
  - Takes the frame candidate plus a frame-end strobe.
  - Owns the debounce counter, the stable value and the zero-gap rule.
  - Drives key_code and key_valid.
- The top level holds the synchroniser, the row/slot counters and hit accumulation.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2 (frame = 16 cycles).
- Reset: hold rst_n=0 for 5 cycles, then release.
  - Required: row_o=0001, key_code=0, key_valid=0.
  - Required: row_o steps 0001→0010 after 4 cycles and returns to 0001 at cycle 16.
- Clean press: model '5' as col_i[1]=1 whenever row_o[1]=1, held 5 frames, then released.
  - Required: key_code=6 with a single key_valid pulse within 32–51 cycles of the press.
  - Required: key_code=0 within 32–51 cycles of the release, with no pulse.
- Bounce: '0' (row 3, col 1) toggles every 7 cycles for 3 frames, then is held.
  - Required: key_code stays 0 during bouncing, then becomes 1 after 2 stable frames.
- Chord: '1' and '2' pressed together for 4 frames.
  - Required: key_code stays 0 and key_valid never pulses.
- Direct change: '3' held until key_code=4, then switched to '#' with no release.
  - Required: key_code goes 4→0 for ≥16 cycles, then 12, with exactly one key_valid pulse on the 0→12 transition.
- Reset mid-press: assert rst_n while key_code=10.
  - Required: key_code=0 and row_o=0001 asynchronously.
  - Required: after release with the key still held, key_code=10 returns with a fresh key_valid pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, matrix geometry and the position-to-code map.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_NONE = 4'd0;
    localparam key_code_t KEY_0    = 4'd1;
    localparam key_code_t KEY_1    = 4'd2;
    localparam key_code_t KEY_2    = 4'd3;
    localparam key_code_t KEY_3    = 4'd4;
    localparam key_code_t KEY_4    = 4'd5;
    localparam key_code_t KEY_5    = 4'd6;
    localparam key_code_t KEY_6    = 4'd7;
    localparam key_code_t KEY_7    = 4'd8;
    localparam key_code_t KEY_8    = 4'd9;
    localparam key_code_t KEY_9    = 4'd10;
    localparam key_code_t KEY_STAR = 4'd11;
    localparam key_code_t KEY_HASH = 4'd12;

    function automatic key_code_t key_map(input logic [1:0] row, input logic [1:0] col);
        key_code_t code;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_NONE;
        endcase
        return code;
    endfunction

    // Zero hits or a chord (two or more hits) both yield KEY_NONE.
    function automatic key_code_t frame_candidate(input logic [NUM_KEYS-1:0] hits);
        key_code_t   code;
        int unsigned count;
        code  = KEY_NONE;
        count = 32'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (hits[r*NUM_COLS + c]) begin
                    count = count + 32'd1;
                    code  = key_map(2'(r), 2'(c));
                end else begin
                    code = code;
                end
            end
        end
        if (count != 32'd1) begin
            code = KEY_NONE;
        end else begin
            code = code;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Key-code interface between the keypad encoder (master) and the lock logic (slave).
interface keypad_encoder_if;
    import keypad_pkg::*;

    key_code_t key_code;
    logic      key_valid;

    modport master (output key_code, output key_valid);
    modport slave  (input  key_code, input  key_valid);
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce of the scan candidate; drives the key code with a forced 0 gap between keys.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_end_i,
    input  key_code_t         cand_i,
    keypad_encoder_if.master  key_if
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    key_code_t  prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    key_code_t  code_q, code_d;
    logic       valid_q, valid_d;
    logic       stable_s;

    // Next-state: run count of identical candidates and output update at frame end.
    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        stable_s = 1'b0;
        if (frame_end_i) begin
            prev_d = cand_i;
            if (cand_i == prev_q) begin
                if (cnt_q >= DEB) begin
                    cnt_d = DEB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd1;
            end
            stable_s = (cnt_d == DEB);
            // A direct key change first drops to 0; the new key loads next frame if still stable.
            if (stable_s && (cand_i != code_q)) begin
                if (code_q == KEY_NONE) begin
                    code_d  = cand_i;
                    valid_d = 1'b1;
                end else begin
                    code_d = KEY_NONE;
                end
            end else begin
                code_d = code_q;
            end
        end else begin
            prev_d = prev_q;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= KEY_NONE;
            cnt_q   <= 4'd0;
            code_q  <= KEY_NONE;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x3 keypad scanner: column synchroniser, row/slot sequencing, per-frame hit capture.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        col_i,
    output logic [3:0]        row_o,
    keypad_encoder_if.master  key_if
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [2:0]          col_meta_q, col_sync_q;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [3:0]          row_q, row_d;
    logic [NUM_KEYS-1:0] hits_q, hits_d, hits_s;
    key_code_t           cand_q, cand_d;
    logic                frame_end_q, frame_end_d;
    logic                slot_last_s, frame_last_s;

    // Scan sequencing and hit capture; the last row's sample is folded in at frame end.
    always_comb begin
        slot_last_s  = (slot_q == SLOT_LAST);
        frame_last_s = slot_last_s && (row_idx_q == 2'd3);
        hits_s       = hits_q;
        if (slot_last_s) begin
            case (row_idx_q)
                2'd0:    hits_s[2:0]  = col_sync_q;
                2'd1:    hits_s[5:3]  = col_sync_q;
                2'd2:    hits_s[8:6]  = col_sync_q;
                2'd3:    hits_s[11:9] = col_sync_q;
                default: hits_s       = hits_q;
            endcase
        end else begin
            hits_s = hits_q;
        end
        if (slot_last_s) begin
            slot_d    = '0;
            row_idx_d = row_idx_q + 2'd1;
            row_d     = {row_q[2:0], row_q[3]};
        end else begin
            slot_d    = slot_q + SLOT_W'(1);
            row_idx_d = row_idx_q;
            row_d     = row_q;
        end
        if (frame_last_s) begin
            hits_d = '0;
            cand_d = frame_candidate(hits_s);
        end else begin
            hits_d = hits_s;
            cand_d = cand_q;
        end
        frame_end_d = frame_last_s;
    end

    // Synchroniser and scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q  <= 3'b000;
            col_sync_q  <= 3'b000;
            slot_q      <= '0;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b0001;
            hits_q      <= '0;
            cand_q      <= KEY_NONE;
            frame_end_q <= 1'b0;
        end else begin
            col_meta_q  <= col_i;
            col_sync_q  <= col_meta_q;
            slot_q      <= slot_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            hits_q      <= hits_d;
            cand_q      <= cand_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign row_o = row_q;

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_end_i (frame_end_q),
        .cand_i      (cand_q),
        .key_if      (key_if)
    );

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: keypad matrix model, frame-level reference model and directed scenarios.
module tb_keypad_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  col_i;
    logic [3:0]  row_o;
    logic [11:0] keys  = 12'd0;   // index = row*3 + col

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;

    keypad_encoder_if key_if();

    keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .col_i  (col_i),
        .row_o  (row_o),
        .key_if (key_if)
    );

    always #5 clk = ~clk;

    // Passive switch matrix: a pressed key connects its row drive to its column.
    always_comb begin
        col_i = 3'b000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (row_o[r] && keys[r*3 + c]) col_i[c] = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge count n since reset; row n/4 mod 4 is driven; the sample for row r of the
    // frame ending at edge fe sees the keys present at edge fe-16+4r+2; output follows one edge later.
    int          n = 0;
    logic [11:0] hist [64];
    int          cq [$];
    logic [3:0]  m_code  = 4'd0;
    logic        m_valid = 1'b0;
    int          code_tbl [12] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 1, 12};
    int          fe, hitcnt, hitidx, cand;
    bit          stable;

    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0; m_code = 4'd0; m_valid = 1'b0; cq.delete();
        end else begin
            n++;
            hist[n % 64] = keys;
            m_valid = 1'b0;
            if (n > 16 && (n - 1) % 16 == 0) begin
                fe = n - 1; hitcnt = 0; hitidx = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 3; c++)
                        if (hist[(fe - 16 + 4*r + 2) % 64][r*3 + c]) begin
                            hitcnt++; hitidx = r*3 + c;
                        end
                cand = (hitcnt == 1) ? code_tbl[hitidx] : 0;
                cq.push_back(cand);
                if (cq.size() > DEBOUNCE) void'(cq.pop_front());
                stable = (cq.size() == DEBOUNCE);
                foreach (cq[i]) if (cq[i] != cand) stable = 1'b0;
                if (stable && cand != int'(m_code)) begin
                    if (m_code == 4'd0) begin m_code = 4'(cand); m_valid = 1'b1; end
                    else m_code = 4'd0;
                end
            end
        end
        #1;
        check("row_o", int'(row_o), 1 << ((n / 4) % 4));
        check("key_code", int'(key_if.key_code), int'(m_code));
        check("key_valid", int'(key_if.key_valid), int'(m_valid));
        if (key_if.key_valid) vcount++;
    end

    // Leaves the caller at the negedge right after row_o returns to row 0.
    task automatic wait_frame_start();
        int guard = 0;
        @(negedge clk);
        while (row_o != 4'b1000 && guard < 40) begin @(negedge clk); guard++; end
        while (row_o == 4'b1000 && guard < 40) begin @(negedge clk); guard++; end
        check("frame_sync", int'(guard < 40), 1);
    endtask

    task automatic wait_code(input int val, input int maxc, input string name, output int cyc);
        cyc = 0;
        while (int'(key_if.key_code) != val && cyc < maxc) begin @(negedge clk); cyc++; end
        check(name, int'(key_if.key_code), val);
    endtask

    int lat, v0, v1, nz, gap;

    initial begin
        // Reset and scan stepping
        repeat (5) @(negedge clk);
        check("rst_row", int'(row_o), 1);
        check("rst_code", int'(key_if.key_code), 0);
        check("rst_valid", int'(key_if.key_valid), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("row_step", int'(row_o), 2);
        repeat (12) @(negedge clk);
        check("row_wrap", int'(row_o), 1);

        // Clean press of '5', held five frames, then released
        wait_frame_start();
        v0 = vcount;
        keys[4] = 1'b1;
        wait_code(6, 60, "press5_code", lat);
        check("press5_lat_in_range", int'(lat >= 32 && lat <= 51), 1);
        repeat (80 - lat) @(negedge clk);
        keys[4] = 1'b0;
        wait_code(0, 60, "release5_code", lat);
        check("release5_lat_in_range", int'(lat >= 32 && lat <= 51), 1);
        check("press5_pulses", vcount - v0, 1);
        repeat (32) @(negedge clk);

        // Bounce on '0', then held
        wait_frame_start();
        repeat (5) @(negedge clk);
        v0 = vcount; nz = 0;
        for (int i = 0; i < 7; i++) begin
            keys[10] = ~keys[10];
            repeat (7) begin
                @(negedge clk);
                if (key_if.key_code != 4'd0) nz++;
            end
        end
        keys[10] = 1'b1;
        check("bounce_quiet", nz, 0);
        wait_code(1, 60, "bounce_settle", lat);
        check("bounce_pulses", vcount - v0, 1);
        keys[10] = 1'b0;
        wait_code(0, 60, "bounce_release", lat);
        repeat (32) @(negedge clk);

        // Chord '1'+'2'
        v0 = vcount; nz = 0;
        keys[0] = 1'b1; keys[1] = 1'b1;
        repeat (64) begin
            @(negedge clk);
            if (key_if.key_code != 4'd0) nz++;
        end
        check("chord_code_zero", nz, 0);
        check("chord_pulses", vcount - v0, 0);
        keys[0] = 1'b0; keys[1] = 1'b0;
        repeat (48) @(negedge clk);

        // Direct change '3' -> '#'
        keys[2] = 1'b1;
        wait_code(4, 60, "direct_first", lat);
        keys[2] = 1'b0; keys[11] = 1'b1;
        v1 = vcount;
        wait_code(0, 60, "direct_gap", lat);
        wait_code(12, 60, "direct_second", gap);
        check("direct_gap_ge16", int'(gap >= 16), 1);
        check("direct_pulses", vcount - v1, 1);
        keys[11] = 1'b0;
        wait_code(0, 60, "direct_release", lat);
        repeat (32) @(negedge clk);

        // Reset while '9' is shown
        keys[8] = 1'b1;
        wait_code(10, 60, "mid_rst_before", lat);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_code", int'(key_if.key_code), 0);
        check("async_rst_row", int'(row_o), 1);
        repeat (3) @(negedge clk);
        v0 = vcount;
        rst_n = 1'b1;
        wait_code(10, 60, "mid_rst_after", lat);
        check("mid_rst_lat_in_range", int'(lat >= 32 && lat <= 51), 1);
        check("mid_rst_pulses", vcount - v0, 1);
        keys[8] = 1'b0;
        wait_code(0, 60, "mid_rst_release", lat);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
